// File: rtl/universal_register.sv
// universal_register: WIDTH-bit register with load, increment/decrement,
// shifts and rotate, a registered carry/borrow/shift-out bit and a
// combinational zero flag. Synchronous active-low reset, soft clear.
module universal_register #(
  parameter int               WIDTH       = 11,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             clear_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] Q,
  output logic             carry_out,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_ROL  = 3'b111
  } op_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic             carry_r;
  logic [WIDTH-1:0] next_q;
  logic             next_carry;

  // Result of the selected operation applied to the current Q.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    next_q     = q_r;
    next_carry = carry_r;
    case (op_e'(op))
      OP_HOLD: begin
        next_q     = q_r;
        next_carry = carry_r;
      end
      OP_LOAD: begin
        next_q     = in;
        next_carry = 1'b0;
      end
      OP_INC: begin
        {next_carry, next_q} = {1'b0, q_r} + {1'b0, ONE};
      end
      OP_DEC: begin
        next_q     = q_r - ONE;
        next_carry = (q_r == '0);
      end
      OP_SHL: begin
        next_q     = {q_r[WIDTH-2:0], serial_in};
        next_carry = q_r[WIDTH-1];
      end
      OP_SHR: begin
        next_q     = {serial_in, q_r[WIDTH-1:1]};
        next_carry = q_r[0];
      end
      OP_ASR: begin
        next_q     = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        next_carry = q_r[0];
      end
      OP_ROL: begin
        next_q     = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        next_carry = q_r[WIDTH-1];
      end
      default: begin
        next_q     = q_r;
        next_carry = carry_r;
      end
    endcase
  end

  // State update: reset, then soft clear, then enabled operation, else hold.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!clear_n) begin
      q_r     <= RESET_VALUE;
      carry_r <= 1'b0;
    end else if (clear) begin
      q_r     <= '0;
      carry_r <= 1'b0;
    end else if (enable) begin
      q_r     <= next_q;
      carry_r <= next_carry;
    end
  end

  assign Q         = q_r;
  assign carry_out = carry_r;
  assign zero      = (q_r == '0);

endmodule
